trap_controller: RTL
====================

TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width; only 32 is supported.
REQ-002 SHALL have clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have trapped  input  1  trap request from the exception detector.
REQ-005 SHALL have trap_status  input  2  trap kind: 00 ECALL, 01 EBREAK, 10 instruction address misaligned, 11 MRET.
REQ-006 SHALL have pc  input  32  address of the trapping instruction.
REQ-007 SHALL have jump_target  input  32  faulting target for the misaligned case.
REQ-008 SHALL have csr_read_data  input  32  combinational CSR file read data for csr_read_address.
REQ-009 SHALL have csr_read_address  output  12  CSR read address.
REQ-010 SHALL have csr_write_enable  output  1  CSR write strobe.
REQ-011 SHALL have csr_write_address  output  12  CSR write address.
REQ-012 SHALL have csr_write_data  output  32  CSR write data.
REQ-013 SHALL have trap_stall  output  1  pipeline hold while a trap or MRET is in progress.
REQ-014 SHALL have trap_redirect  output  1  one-cycle PC redirect pulse.
REQ-015 SHALL have trap_target  output  32  redirect address; valid while trap_redirect=1.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE_MEPC, WRITE_MCAUSE, WRITE_MTVAL, READ_VECTOR, READ_MEPC, REDIRECT.
REQ-017 In IDLE with trapped=1, SHALL register pc, jump_target and trap_status, then go to READ_MEPC for 11 and to WRITE_MEPC otherwise; trap_stall SHALL be 1 combinationally in that same cycle.
REQ-018 WRITE_MEPC SHALL drive write enable=1, address 0x341, data = captured pc, then go to WRITE_MCAUSE.
REQ-019 WRITE_MCAUSE SHALL write address 0x342 with cause 32'd11 for ECALL, 32'd3 for EBREAK, or 32'd0 for misaligned, then go to WRITE_MTVAL.
REQ-020 WRITE_MTVAL SHALL write address 0x343 with 0 for ECALL, captured pc for EBREAK, or captured jump_target for misaligned, then go to READ_VECTOR.
REQ-021 READ_VECTOR SHALL drive csr_read_address=0x305 and register trap_target={csr_read_data[31:2],2'b00} (direct mode only; mode bits ignored), then go to REDIRECT.
REQ-022 READ_MEPC SHALL drive csr_read_address=0x341 and register trap_target={csr_read_data[31:2],2'b00}, then go to REDIRECT.
REQ-023 REDIRECT SHALL assert trap_redirect for exactly one cycle, then go to IDLE.
REQ-024 With trapped accepted at cycle T, trap_redirect SHALL be 1 in cycle T+5 for exceptions and T+2 for MRET.
REQ-025 trap_stall SHALL be 1 in every non-IDLE state, including REDIRECT.
REQ-026 Outside the write states, csr_write_enable SHALL be 0 and csr_write_address/data SHALL be 0; outside the read states, csr_read_address SHALL be 0.
REQ-027 trapped SHALL be ignored in every non-IDLE state; a level held high SHALL be accepted again only on return to IDLE (back-to-back traps allowed).
REQ-028 trap_target SHALL hold its last value after REDIRECT until the next read state or reset.

Reset
REQ-029 With reset=1 at a clock edge, the FSM SHALL enter IDLE and all outputs and captured registers SHALL be 0, overriding trapped in the same cycle.
REQ-030 Reset mid-sequence SHALL abort it with no further CSR writes and no redirect.

Verification
REQ-031 ECALL, pc=0x100, mtvec=0x200 -> writes 0x341=0x100, 0x342=11, 0x343=0; redirect at T+5 with target 0x200.
REQ-032 EBREAK, pc=0x104, mtvec=0x203 -> mcause=3, mtval=0x104; target 0x200.
REQ-033 Misaligned, pc=0x108, jump_target=0xF1 -> mcause=0, mtval=0xF1; redirect at T+5.
REQ-034 MRET with mepc=0x10A -> no CSR writes; redirect at T+2 with target 0x108.
REQ-035 trapped held high for 12 cycles with ECALL -> exactly two complete sequences, the second accepted in the IDLE cycle after the first REDIRECT.
REQ-036 reset asserted during WRITE_MCAUSE -> next cycle IDLE with all outputs 0, no 0x343 write, and no trap_redirect.

Source files
------------

// File: rtl/trap_controller.sv
// Trap sequencer: saves mepc/mcause/mtval through the CSR write port on an
// exception, reads mtvec (or mepc for MRET) and issues a one-cycle PC redirect.
module trap_controller #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trapped,
  input  logic [1:0]      trap_status,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] csr_read_data,
  output logic [11:0]     csr_read_address,
  output logic            csr_write_enable,
  output logic [11:0]     csr_write_address,
  output logic [XLEN-1:0] csr_write_data,
  output logic            trap_stall,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_target
);

  localparam int unsigned CSR_AW = 12;
  localparam logic [CSR_AW-1:0] ADDR_MTVEC  = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] ADDR_MEPC   = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] ADDR_MCAUSE = CSR_AW'(12'h342);
  localparam logic [CSR_AW-1:0] ADDR_MTVAL  = CSR_AW'(12'h343);

  localparam logic [1:0] KIND_ECALL  = 2'b00;
  localparam logic [1:0] KIND_EBREAK = 2'b01;
  localparam logic [1:0] KIND_MRET   = 2'b11;

  localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_MISAL  = XLEN'(0);
  localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(3);

  typedef enum logic [2:0] {
    IDLE,
    WRITE_MEPC,
    WRITE_MCAUSE,
    WRITE_MTVAL,
    READ_VECTOR,
    READ_MEPC,
    REDIRECT
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [XLEN-1:0] cap_pc;
  logic [XLEN-1:0] cap_jump_target;
  logic [1:0]      cap_status;
  logic            accept;

  assign accept = (state == IDLE) && trapped;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Trap context captured at acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_pc          <= '0;
      cap_jump_target <= '0;
      cap_status      <= '0;
    end else if (accept) begin
      cap_pc          <= pc;
      cap_jump_target <= jump_target;
      cap_status      <= trap_status;
    end
  end

  // Redirect address, word-aligned; direct-mode vectoring only
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_target <= '0;
    end else if ((state == READ_VECTOR) || (state == READ_MEPC)) begin
      trap_target <= csr_read_data & ALIGN_MASK;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (trapped) next_state = (trap_status == KIND_MRET) ? READ_MEPC : WRITE_MEPC;
      end
      WRITE_MEPC:   next_state = WRITE_MCAUSE;
      WRITE_MCAUSE: next_state = WRITE_MTVAL;
      WRITE_MTVAL:  next_state = READ_VECTOR;
      READ_VECTOR:  next_state = REDIRECT;
      READ_MEPC:    next_state = REDIRECT;
      REDIRECT:     next_state = IDLE;
      default:      next_state = IDLE;
    endcase
  end

  // Output decode; stall also rises in the accepting IDLE cycle
  always_comb begin
    csr_read_address  = '0;
    csr_write_enable  = 1'b0;
    csr_write_address = '0;
    csr_write_data    = '0;
    trap_redirect     = 1'b0;
    trap_stall        = (state != IDLE) || trapped;
    unique case (state)
      WRITE_MEPC: begin
        csr_write_enable  = 1'b1;
        csr_write_address = ADDR_MEPC;
        csr_write_data    = cap_pc;
      end
      WRITE_MCAUSE: begin
        csr_write_enable  = 1'b1;
        csr_write_address = ADDR_MCAUSE;
        case (cap_status)
          KIND_ECALL:  csr_write_data = CAUSE_ECALL;
          KIND_EBREAK: csr_write_data = CAUSE_EBREAK;
          default:     csr_write_data = CAUSE_MISAL;
        endcase
      end
      WRITE_MTVAL: begin
        csr_write_enable  = 1'b1;
        csr_write_address = ADDR_MTVAL;
        case (cap_status)
          KIND_ECALL:  csr_write_data = '0;
          KIND_EBREAK: csr_write_data = cap_pc;
          default:     csr_write_data = cap_jump_target;
        endcase
      end
      READ_VECTOR: csr_read_address = ADDR_MTVEC;
      READ_MEPC:   csr_read_address = ADDR_MEPC;
      REDIRECT:    trap_redirect = 1'b1;
      default: ;
    endcase
  end

endmodule
